// File: rtl/assign_gates_pkg.sv
// Shared constants for the assign_gates block: bit positions of each gate
// result in the 8-bit gate vector and the vector's reset value (a=0, b=0).
package assign_gates_pkg;

    localparam int GATE_N = 8;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_XOR  = 2;
    localparam int IDX_ANOT = 3;
    localparam int IDX_BNOT = 4;
    localparam int IDX_NAND = 5;
    localparam int IDX_NOR  = 6;
    localparam int IDX_XNOR = 7;

    // Gate results of the pair a=0, b=0: the inverting gates read 1.
    localparam logic [GATE_N-1:0] GATE_RST = 8'b1111_1000;

endpackage

// File: rtl/assign_gates_gate_eval.sv
// gate_eval: purely combinational evaluation of all eight two-input gate
// results, packed by the index constants of assign_gates_pkg.
module gate_eval
    import assign_gates_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_N-1:0] gates
);

    always_comb begin
        gates           = '0;
        gates[IDX_AND]  = a & b;
        gates[IDX_OR]   = a | b;
        gates[IDX_XOR]  = a ^ b;
        gates[IDX_ANOT] = ~a;
        gates[IDX_BNOT] = ~b;
        gates[IDX_NAND] = ~(a & b);
        gates[IDX_NOR]  = ~(a | b);
        gates[IDX_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/assign_gates.sv
// assign_gates: registers the eight gate results of each accepted sample.
// Optional sample statistics (combo_seen, sample_cnt) via ASSIGN_GATES_STATS_EN.
module assign_gates
    import assign_gates_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a_in,
    input  logic             b_in,
    output logic             and_out,
    output logic             or_out,
    output logic             xor_out,
    output logic             anot_out,
    output logic             bnot_out,
    output logic             nand_out,
    output logic             nor_out,
    output logic             xnor_out,
    output logic             out_valid,
    output logic [3:0]       combo_seen,
    output logic [CNT_W-1:0] sample_cnt
);

    logic [GATE_N-1:0] gates_d;
    logic [GATE_N-1:0] gates_q;
    logic              valid_q;

    gate_eval u_gate_eval (
        .a     (a_in),
        .b     (b_in),
        .gates (gates_d)
    );

    // Gate vector only moves on accepted samples, so it holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gates_q <= GATE_RST;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                gates_q <= gates_d;
            end
        end
    end

    assign and_out   = gates_q[IDX_AND];
    assign or_out    = gates_q[IDX_OR];
    assign xor_out   = gates_q[IDX_XOR];
    assign anot_out  = gates_q[IDX_ANOT];
    assign bnot_out  = gates_q[IDX_BNOT];
    assign nand_out  = gates_q[IDX_NAND];
    assign nor_out   = gates_q[IDX_NOR];
    assign xnor_out  = gates_q[IDX_XNOR];
    assign out_valid = valid_q;

`ifdef ASSIGN_GATES_STATS_EN
    logic [3:0]       seen_q;
    logic [CNT_W-1:0] cnt_q;

    // Counter stops at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
            cnt_q  <= '0;
        end else if (in_valid) begin
            seen_q[{a_in, b_in}] <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign combo_seen = seen_q;
    assign sample_cnt = cnt_q;
`else
    assign combo_seen = '0;
    assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_assign_gates.sv
// Self-checking bench for assign_gates: scoreboard of expected gate vectors,
// plus a CNT_W=2 instance for counter saturation.
module tb_assign_gates;

`ifdef ASSIGN_GATES_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       a_in;
    logic       b_in;

    logic       and_out, or_out, xor_out, anot_out, bnot_out;
    logic       nand_out, nor_out, xnor_out, out_valid;
    logic [3:0] combo_seen;
    logic [7:0] sample_cnt;

    logic       s_and, s_or, s_xor, s_anot, s_bnot, s_nand, s_nor, s_xnor;
    logic       s_valid;
    logic [3:0] s_seen;
    logic [1:0] s_cnt;

    int         errors;
    int         checks;
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic [3:0] seen_model;
    logic [7:0] cnt_model;
    logic [1:0] cnt2_model;

    assign_gates #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a_in       (a_in),
        .b_in       (b_in),
        .and_out    (and_out),
        .or_out     (or_out),
        .xor_out    (xor_out),
        .anot_out   (anot_out),
        .bnot_out   (bnot_out),
        .nand_out   (nand_out),
        .nor_out    (nor_out),
        .xnor_out   (xnor_out),
        .out_valid  (out_valid),
        .combo_seen (combo_seen),
        .sample_cnt (sample_cnt)
    );

    assign_gates #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a_in       (a_in),
        .b_in       (b_in),
        .and_out    (s_and),
        .or_out     (s_or),
        .xor_out    (s_xor),
        .anot_out   (s_anot),
        .bnot_out   (s_bnot),
        .nand_out   (s_nand),
        .nor_out    (s_nor),
        .xnor_out   (s_xnor),
        .out_valid  (s_valid),
        .combo_seen (s_seen),
        .sample_cnt (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: and, or, xor, anot, bnot, nand, nor, xnor (bit 0 first).
    function automatic logic [7:0] gate_model(input logic a, input logic b);
        logic [7:0] g;
        g[0] = a & b;
        g[1] = a | b;
        g[2] = a ^ b;
        g[3] = ~a;
        g[4] = ~b;
        g[5] = ~(a & b);
        g[6] = ~(a | b);
        g[7] = ~(a ^ b);
        return g;
    endfunction

    function automatic logic [7:0] dut_gates();
        return {xnor_out, nor_out, nand_out, bnot_out, anot_out, xor_out, or_out, and_out};
    endfunction

    function automatic logic [7:0] sat_gates();
        return {s_xnor, s_nor, s_nand, s_bnot, s_anot, s_xor, s_or, s_and};
    endfunction

    task automatic clear_models();
        exp_q.delete();
        held       = 8'hF8;
        seen_model = '0;
        cnt_model  = '0;
        cnt2_model = '0;
    endtask

    // Drives one cycle; valid samples push their expectation and update stats models.
    task automatic drive(input logic v, input logic a, input logic b, input logic [7:0] exp);
        in_valid = v;
        a_in     = a;
        b_in     = b;
        if (v) begin
            exp_q.push_back(exp);
            seen_model[{a, b}] = 1'b1;
            if (cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
            if (cnt2_model != 2'd3) cnt2_model = cnt2_model + 2'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = 1'b0;
        b_in     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] g;
        #3;
        rst_n = 1'b0;
        #1;
        g = dut_gates();
        checks++;
        if (g !== 8'hF8) begin
            errors++;
            $display("[TB] FAIL reset_gates: got %h want f8", g);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (combo_seen !== 4'd0 || sample_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got seen=%b cnt=%0d want 0/0", combo_seen, sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
        @(posedge clk);
        #1;
    endtask

    task automatic test_truth_table();
        logic [7:0] table_exp[4];
        logic [7:0] g;
        logic [1:0] ab;
        table_exp[0] = 8'hF8;
        table_exp[1] = 8'h2E;
        table_exp[2] = 8'h36;
        table_exp[3] = 8'h83;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            drive(1'b1, ab[1], ab[0], table_exp[i]);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL tt_valid[%0d]: got %b want 1", i, out_valid);
            end
            if (exp_q.size() != 0) held = exp_q.pop_front();
            g = dut_gates();
            checks++;
            if (g !== held) begin
                errors++;
                $display("[TB] FAIL tt_gates[%0d]: got %h want %h", i, g, held);
            end
            checks++;
            if (combo_seen !== (STATS_EN ? seen_model : 4'd0) ||
                sample_cnt !== (STATS_EN ? cnt_model : 8'd0)) begin
                errors++;
                $display("[TB] FAIL tt_stats[%0d]: got seen=%b cnt=%0d want seen=%b cnt=%0d", i,
                         combo_seen, sample_cnt, STATS_EN ? seen_model : 4'd0,
                         STATS_EN ? cnt_model : 8'd0);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] g;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], ~i[1], 8'h00);
            g = dut_gates();
            checks++;
            if (out_valid !== 1'b0 || g !== held) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: got valid=%b gates=%h want valid=0 gates=%h",
                         i, out_valid, g, held);
            end
        end
        checks++;
        if (sample_cnt !== (STATS_EN ? cnt_model : 8'd0)) begin
            errors++;
            $display("[TB] FAIL hold_cnt: got %0d want %0d", sample_cnt, STATS_EN ? cnt_model : 8'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic       v, a, b;
        logic [7:0] g;
        for (int i = 0; i < 24; i++) begin
            v = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            drive(v, a, b, gate_model(a, b));
            checks++;
            if (out_valid !== v) begin
                errors++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, v);
            end
            if (v && exp_q.size() != 0) held = exp_q.pop_front();
            g = dut_gates();
            checks++;
            if (g !== held) begin
                errors++;
                $display("[TB] FAIL b2b_gates[%0d]: got %h want %h", i, g, held);
            end
        end
        checks++;
        if (combo_seen !== (STATS_EN ? seen_model : 4'd0) ||
            sample_cnt !== (STATS_EN ? cnt_model : 8'd0)) begin
            errors++;
            $display("[TB] FAIL b2b_stats: got seen=%b cnt=%0d want seen=%b cnt=%0d",
                     combo_seen, sample_cnt, STATS_EN ? seen_model : 4'd0, STATS_EN ? cnt_model : 8'd0);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] g;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i[0], i[1], gate_model(i[0], i[1]));
            if (exp_q.size() != 0) held = exp_q.pop_front();
            g = sat_gates();
            checks++;
            if (s_valid !== 1'b1 || g !== held) begin
                errors++;
                $display("[TB] FAIL sat_gates[%0d]: got valid=%b gates=%h want valid=1 gates=%h",
                         i, s_valid, g, held);
            end
            checks++;
            if (s_cnt !== (STATS_EN ? cnt2_model : 2'd0) ||
                sample_cnt !== (STATS_EN ? cnt_model : 8'd0)) begin
                errors++;
                $display("[TB] FAIL sat_cnt[%0d]: got cnt2=%0d cnt8=%0d want cnt2=%0d cnt8=%0d", i,
                         s_cnt, sample_cnt, STATS_EN ? cnt2_model : 2'd0, STATS_EN ? cnt_model : 8'd0);
            end
        end
        checks++;
        if (s_seen !== (STATS_EN ? 4'b1111 : 4'd0)) begin
            errors++;
            $display("[TB] FAIL sat_seen: got %b want %b", s_seen, STATS_EN ? 4'b1111 : 4'd0);
        end
    endtask

    task automatic test_midstream_reset();
        logic [7:0] g;
        drive(1'b1, 1'b1, 1'b0, gate_model(1'b1, 1'b0));
        if (exp_q.size() != 0) held = exp_q.pop_front();
        in_valid = 1'b1;
        a_in     = 1'b0;
        b_in     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        clear_models();
        g = dut_gates();
        checks++;
        if (g !== 8'hF8 || out_valid !== 1'b0 || combo_seen !== 4'd0 || sample_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got gates=%h valid=%b seen=%b cnt=%0d want f8/0/0/0",
                     g, out_valid, combo_seen, sample_cnt);
        end
        @(posedge clk);
        #1;
        g = dut_gates();
        checks++;
        if (g !== 8'hF8 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_held: got gates=%h valid=%b want f8/0", g, out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h83);
        if (exp_q.size() != 0) held = exp_q.pop_front();
        checks++;
        if (and_out !== 1'b1 || out_valid !== 1'b1 || dut_gates() !== held) begin
            errors++;
            $display("[TB] FAIL post_reset: got and=%b valid=%b gates=%h want 1/1/%h",
                     and_out, out_valid, dut_gates(), held);
        end
        checks++;
        if (sample_cnt !== (STATS_EN ? 8'd1 : 8'd0) || combo_seen !== (STATS_EN ? 4'b1000 : 4'd0)) begin
            errors++;
            $display("[TB] FAIL post_reset_stats: got cnt=%0d seen=%b want %0d/%b", sample_cnt,
                     combo_seen, STATS_EN ? 8'd1 : 8'd0, STATS_EN ? 4'b1000 : 4'd0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a_in     = 1'b0;
        b_in     = 1'b0;
        clear_models();
        test_reset();
        test_truth_table();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
